// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory bus between instruction fetch and the MEM stage.
// MEM goes first; the pipeline is held until every pending access of the cycle is served.
module mem_port_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 32'd256
) (
   input  logic        ACLK,
   input  logic        ARESETn,
   input  logic        if_req_i,
   input  logic [31:0] if_addr_i,
   output logic [31:0] if_rdata_o,
   input  logic        mem_read_c_i,
   input  logic        mem_write_c_i,
   input  logic [31:0] mem_addr_i,
   input  logic [31:0] mem_wdata_i,
   input  logic [3:0]  mem_wstrb_i,
   output logic [31:0] mem_rdata_o,
   output logic        stall_c_o,
   output logic        bus_req_o,
   output logic        bus_we_o,
   output logic [31:0] bus_addr_o,
   output logic [31:0] bus_wdata_o,
   output logic [3:0]  bus_wstrb_o,
   input  logic        bus_gnt_i,
   input  logic        bus_rvalid_i,
   input  logic [31:0] bus_rdata_i,
   output logic        err_o
);

   localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 32'd1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 32'd1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(32'd0);
   localparam logic             TO_EN    = (TIMEOUT_CYCLES != 32'd0);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t            state_r;
   state_t            state_nxt_s;
   logic              owner_mem_r;
   logic              if_served_r;
   logic              mem_served_r;
   logic [CNT_W-1:0]  cnt_r;
   logic              bus_req_r;
   logic              bus_we_r;
   logic [31:0]       bus_addr_r;
   logic [31:0]       bus_wdata_r;
   logic [3:0]        bus_wstrb_r;
   logic [31:0]       if_rdata_r;
   logic [31:0]       mem_rdata_r;
   logic              err_r;

   logic              mem_act_s;
   logic              if_pend_s;
   logic              mem_pend_s;
   logic              busy_s;
   logic              timeout_s;
   logic              rvalid_ok_s;
   logic              abort_s;
   logic              done_s;
   logic              if_resp_s;
   logic              mem_resp_s;
   logic              if_done_s;
   logic              mem_done_s;
   logic              stall_s;
   logic              start_s;
   logic              start_mem_s;
   logic [31:0]       resp_data_s;

   assign mem_act_s   = mem_read_c_i | mem_write_c_i;
   assign if_pend_s   = if_req_i & ~if_served_r;
   assign mem_pend_s  = mem_act_s & ~mem_served_r;
   assign busy_s      = (state_r == ST_REQ) | (state_r == ST_RESP);
   assign timeout_s   = TO_EN & busy_s & (cnt_r == CNT_LAST);
   assign rvalid_ok_s = (state_r == ST_RESP) & bus_rvalid_i;
   // A response landing in the last allowed cycle still counts as a real response.
   assign abort_s     = timeout_s & ~rvalid_ok_s;
   assign done_s      = rvalid_ok_s | abort_s;
   assign resp_data_s = rvalid_ok_s ? bus_rdata_i : 32'd0;
   assign if_resp_s   = done_s & ~owner_mem_r;
   assign mem_resp_s  = done_s & owner_mem_r;
   assign if_done_s   = if_served_r | if_resp_s;
   assign mem_done_s  = mem_served_r | mem_resp_s;
   assign stall_s     = (if_req_i & ~if_done_s) | (mem_act_s & ~mem_done_s);

   // State register of the access sequencer.
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic and requester selection.
   always_comb begin
      state_nxt_s = state_r;
      start_s     = 1'b0;
      start_mem_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (mem_pend_s) begin
               start_s     = 1'b1;
               start_mem_s = 1'b1;
               state_nxt_s = ST_REQ;
            end else if (if_pend_s) begin
               start_s     = 1'b1;
               start_mem_s = 1'b0;
               state_nxt_s = ST_REQ;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_REQ: begin
            if (abort_s) begin
               state_nxt_s = ST_IDLE;
            end else if (bus_gnt_i) begin
               state_nxt_s = ST_RESP;
            end else begin
               state_nxt_s = ST_REQ;
            end
         end
         ST_RESP: begin
            if (done_s) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_RESP;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // Bus fields, timeout counter, response capture and served bookkeeping.
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         owner_mem_r  <= 1'b0;
         if_served_r  <= 1'b0;
         mem_served_r <= 1'b0;
         cnt_r        <= CNT_ZERO;
         bus_req_r    <= 1'b0;
         bus_we_r     <= 1'b0;
         bus_addr_r   <= 32'd0;
         bus_wdata_r  <= 32'd0;
         bus_wstrb_r  <= 4'd0;
         if_rdata_r   <= 32'd0;
         mem_rdata_r  <= 32'd0;
         err_r        <= 1'b0;
      end else begin
         bus_req_r <= (state_nxt_s == ST_REQ);
         if (start_s) begin
            owner_mem_r <= start_mem_s;
            cnt_r       <= CNT_ZERO;
            bus_addr_r  <= start_mem_s ? mem_addr_i : if_addr_i;
            bus_we_r    <= start_mem_s & mem_write_c_i;
            bus_wdata_r <= (start_mem_s & mem_write_c_i) ? mem_wdata_i : 32'd0;
            bus_wstrb_r <= (start_mem_s & mem_write_c_i) ? mem_wstrb_i : 4'd0;
         end else if (busy_s) begin
            cnt_r <= cnt_r + CNT_ONE;
         end
         if (if_resp_s) begin
            if_rdata_r <= resp_data_s;
         end
         if (mem_resp_s && !bus_we_r) begin
            mem_rdata_r <= resp_data_s;
         end
         if (abort_s) begin
            err_r <= 1'b1;
         end
         // Flags only live until the pipeline advances; that edge starts a fresh set.
         if (!stall_s) begin
            if_served_r  <= 1'b0;
            mem_served_r <= 1'b0;
         end else begin
            if (if_resp_s) begin
               if_served_r <= 1'b1;
            end
            if (mem_resp_s) begin
               mem_served_r <= 1'b1;
            end
         end
      end
   end

   assign if_rdata_o  = if_rdata_r;
   assign mem_rdata_o = mem_rdata_r;
   assign stall_c_o   = stall_s;
   assign bus_req_o   = bus_req_r;
   assign bus_we_o    = bus_we_r;
   assign bus_addr_o  = bus_addr_r;
   assign bus_wdata_o = bus_wdata_r;
   assign bus_wstrb_o = bus_wstrb_r;
   assign err_o       = err_r;

endmodule
